// File: rtl/uart_tx_frame_ctrl_if.sv
// Handshake and mux-drive bundle between the word source, the frame sequencer
// and the registered tx output mux.
interface uart_tx_frame_ctrl_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] p_data;
  logic              data_valid;
  logic              par_en;
  logic              par_typ;
  logic              tx_ready;
  logic [2:0]        mux_sel;
  logic              start_bit;
  logic              ser_data;
  logic              parity_bit;
  logic              stop_bit;

  modport master (
    output p_data, data_valid, par_en, par_typ,
    input  tx_ready, mux_sel, start_bit, ser_data, parity_bit, stop_bit
  );

  modport slave (
    input  p_data, data_valid, par_en, par_typ,
    output tx_ready, mux_sel, start_bit, ser_data, parity_bit, stop_bit
  );
endinterface

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame sequencer: walks START, DATA (LSB first), optional PARITY
// and STOP, one bit per baud clock, and drives the select/bit inputs of the tx mux.
module uart_tx_frame_ctrl #(
  parameter int unsigned DATA_W = 8
) (
  input logic                 clk,
  input logic                 rst,
  uart_tx_frame_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [DATA_W-1:0]   shift_reg;
  logic [CNT_W-1:0]    bit_cnt;
  logic                parity_q;
  logic                par_en_q;
  logic                accept;
  logic                last_bit;
  logic                ready;
  logic [2:0]          sel;

  assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));
  assign accept   = bus.data_valid && ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Unused encodings 5..7 fall to the default arm: not ready, mux idle, next IDLE.
  always_comb begin
    state_d = IDLE;
    ready   = 1'b0;
    sel     = 3'd0;
    case (state_q)
      IDLE: begin
        ready   = 1'b1;
        sel     = 3'd0;
        state_d = accept ? START : IDLE;
      end
      START: begin
        sel     = 3'd1;
        state_d = DATA;
      end
      DATA: begin
        sel = 3'd2;
        if (last_bit) begin
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        sel     = 3'd3;
        state_d = STOP;
      end
      STOP: begin
        ready   = 1'b1;
        sel     = 3'd4;
        state_d = accept ? START : IDLE;
      end
      default: begin
        ready   = 1'b0;
        sel     = 3'd0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      parity_q  <= 1'b0;
      par_en_q  <= 1'b0;
    end else if (accept) begin
      shift_reg <= bus.p_data;
      bit_cnt   <= '0;
      parity_q  <= (^bus.p_data) ^ bus.par_typ;
      par_en_q  <= bus.par_en;
    end else if (state_q == DATA) begin
      shift_reg <= {1'b0, shift_reg[DATA_W-1:1]};
      bit_cnt   <= bit_cnt + CNT_W'(1);
    end
  end

  assign bus.tx_ready   = ready;
  assign bus.mux_sel    = sel;
  assign bus.start_bit  = 1'b0;
  assign bus.stop_bit   = 1'b1;
  assign bus.ser_data   = shift_reg[0];
  assign bus.parity_bit = parity_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Scoreboard bench for uart_tx_frame_ctrl: stimulus queues the expected per-cycle
// mux drive of each frame, a negedge monitor pops and compares every non-IDLE cycle.
module tb_uart_tx_frame_ctrl;

  logic clk;
  logic rst;

  uart_tx_frame_ctrl_if #(.DATA_W(8)) bus_if ();

  uart_tx_frame_ctrl #(.DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] sel;
    logic       ser;
    logic       par;
    logic       rdy;
    logic       contig;
    logic       chk_ser;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  logic prev_active = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event t=%0t", name, $time);
  endtask

  // Monitor: every non-IDLE cycle must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_active = 1'b0;
    end else begin
      if (bus_if.mux_sel != 3'd0) begin
        if (q.size() == 0) begin
          check("unexpected_output", {5'd0, bus_if.mux_sel}, 8'd0);
        end else begin
          e = q.pop_front();
          check("mux_sel", {5'd0, bus_if.mux_sel}, {5'd0, e.sel});
          if (e.chk_ser) check("ser_data", {7'd0, bus_if.ser_data}, {7'd0, e.ser});
          check("parity_bit", {7'd0, bus_if.parity_bit}, {7'd0, e.par});
          check("tx_ready", {7'd0, bus_if.tx_ready}, {7'd0, e.rdy});
          if (e.contig) check("idle_gap", {7'd0, prev_active}, 8'd1);
        end
      end
      prev_active = (bus_if.mux_sel != 3'd0);
    end
  end

  task automatic push_frame(input logic [7:0] d, input logic pe, input logic par, input logic contig);
    q.push_back('{sel: 3'd1, ser: 1'b0, par: par, rdy: 1'b0, contig: contig, chk_ser: 1'b0});
    for (int i = 0; i < 8; i++)
      q.push_back('{sel: 3'd2, ser: d[i], par: par, rdy: 1'b0, contig: 1'b0, chk_ser: 1'b1});
    if (pe)
      q.push_back('{sel: 3'd3, ser: 1'b0, par: par, rdy: 1'b0, contig: 1'b0, chk_ser: 1'b0});
    q.push_back('{sel: 3'd4, ser: 1'b0, par: par, rdy: 1'b1, contig: 1'b0, chk_ser: 1'b0});
  endtask

  // Returns one #1 after the accepting edge; keep leaves data_valid asserted.
  task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                      input logic par_exp, input logic contig, input logic keep);
    int n;
    @(posedge clk); #1;
    bus_if.p_data     = d;
    bus_if.par_en     = pe;
    bus_if.par_typ    = pt;
    bus_if.data_valid = 1'b1;
    push_frame(d, pe, par_exp, contig);
    n = 0;
    while (!bus_if.tx_ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 60) begin
      fail_bound("accept_wait");
      bus_if.data_valid = 1'b0;
      q.delete();
    end else begin
      @(posedge clk); #1;
      if (!keep) bus_if.data_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (n >= 100) begin
      fail_bound("frame_drain");
      q.delete();
    end
    @(negedge clk);
    check("idle_after_frame", {5'd0, bus_if.mux_sel}, 8'd0);
    check("ready_after_frame", {7'd0, bus_if.tx_ready}, 8'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst               = 1'b0;
    bus_if.p_data     = '0;
    bus_if.data_valid = 1'b0;
    bus_if.par_en     = 1'b0;
    bus_if.par_typ    = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_mux_sel", {5'd0, bus_if.mux_sel}, 8'd0);
    check("rst_tx_ready", {7'd0, bus_if.tx_ready}, 8'd1);
    check("rst_parity", {7'd0, bus_if.parity_bit}, 8'd0);
    check("rst_ser_data", {7'd0, bus_if.ser_data}, 8'd0);
    check("start_bit", {7'd0, bus_if.start_bit}, 8'd0);
    check("stop_bit", {7'd0, bus_if.stop_bit}, 8'd1);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_after_reset", {5'd0, bus_if.mux_sel}, 8'd0);
    end

    // Even parity, A5 has four ones -> 0
    send(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_done();

    // No parity: 10 non-IDLE cycles, no PARITY
    send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_done();

    // Odd parity -> 1
    send(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_done();

    // Back-to-back: STOP straight into START
    send(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_done();

    // Request while busy is dropped
    send(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    bus_if.p_data     = 8'h00;
    bus_if.par_typ    = 1'b1;
    bus_if.data_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.data_valid = 1'b0;
    wait_done();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("busy_pulse_dropped", {5'd0, bus_if.mux_sel}, 8'd0);
    end

    // Reset during DATA bit 3
    send(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    #1;
    check("abort_mux_sel", {5'd0, bus_if.mux_sel}, 8'd0);
    check("abort_tx_ready", {7'd0, bus_if.tx_ready}, 8'd1);
    check("abort_parity", {7'd0, bus_if.parity_bit}, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_stays_idle", {5'd0, bus_if.mux_sel}, 8'd0);
    send(8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_done();

    repeat (2) @(negedge clk);
    check("queue_drained", 8'(q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
